mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one pipelined WIDTH x WIDTH multiplier (DSP-mapped) among NUM_REQ requesters.
- Round-robin arbitration, per-requester valid/ready request ports, and a single tagged response port with backpressure.
- Sits between requester datapaths and the shared DSP multiply. The product is truncated to WIDTH bits (low half).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width.
- MUL_LATENCY, 3, pipeline stages from accept to result (1..4).
- ID_W, 2, requester tag width; must be >= clog2(NUM_REQ).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept; at most one bit high.
- req_a, input, NUM_REQ*WIDTH, packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_b, input, NUM_REQ*WIDTH, packed operand B, same packing.
- resp_valid, output, 1, result valid.
- resp_ready, input, 1, consumer accepts result.
- resp_id, output, ID_W, index of the requester that owns resp_p.
- resp_p, output, WIDTH, (a*b) mod 2^WIDTH.
- inflight, output, 3, number of ops currently in the pipeline (0..MUL_LATENCY).

Behaviour:
- Reset (async, immediate):
  - resp_valid=0, resp_id=0, resp_p=0, inflight=0.
  - All stage valids cleared.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Ops in flight are discarded; no response is emitted for them.
- Pipeline:
  - MUL_LATENCY stages, each holding {valid, id, product}.
  - The last stage drives resp_*.
  - adv = !(resp_valid && !resp_ready).
  - When adv=1, all stages shift by one. When adv=0, all stages hold; this is a full stall, with no bubble collapsing.
- Arbitration (combinational):
  - Only when adv=1: grant the first i with req_valid[i]=1, scanning from ptr+1 upward modulo NUM_REQ.
  - req_ready[i]=1 only for the granted i. When adv=0, all req_ready=0.
  - Handshake fires when req_valid[i] && req_ready[i].
  - On the handshake: ptr <= i; stage 0 loads valid=1, id=i, and the product of req_a[i] and req_b[i].
  - With no handshake while adv=1: stage 0 loads valid=0 and ptr holds.
  - req_ready never depends on resp_ready except through adv.
- Latency and throughput:
  - Handshake at edge t -> resp_valid=1 with that result after MUL_LATENCY edges, provided there is no stall.
  - Throughput is one op per cycle.
  - Requester order in the response stream equals grant order.
- Arithmetic: full 2*WIDTH unsigned product, low WIDTH bits kept. Example: 0xFFFF*0xFFFF -> 0x0001.
- inflight:
  - Increments on a handshake.
  - Decrements on an output handshake (resp_valid && resp_ready).
  - Unchanged when both or neither happen.
  - Never exceeds MUL_LATENCY.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - A single requester held valid is granted every cycle.
  - Pointer wrap from NUM_REQ-1 to 0.
  - Stall with a full pipeline: no grants, and resp_* held stable until resp_ready.
  - Reset asserted mid-stall: outputs clear immediately.
  - req_valid deasserted without a handshake is legal (no data retained).
  - resp_p/resp_id are don't-care when resp_valid=0, but the RTL holds the last value.

Test Plan:
- Reset, then req_valid=4'b0001, a0=3, b0=5, resp_ready=1 -> req_ready=4'b0001 in the same cycle; MUL_LATENCY(3) cycles later resp_valid=1, resp_id=0, resp_p=15; inflight 1 then 0.
- All four valid for 8 cycles, a_i=i+1, b_i=2, resp_ready=1 -> grant order 0,1,2,3,0,1,2,3; responses p=2,4,6,8 repeating with matching ids, one per cycle.
- Fill the pipeline, then resp_ready=0 for 5 cycles -> req_ready=0, resp_* stable, inflight=3; on release, 3 results drain in order, no loss or duplication.
- a=0xFFFF, b=0xFFFF, requester 2 -> resp_p=0x0001, resp_id=2; a=0x0100, b=0x0100 -> resp_p=0x0000.
- Assert rst with 2 ops in flight -> resp_valid=0 and inflight=0 immediately; after release, requester 0 wins over 3 when both are valid.
- Random valid/ready traffic for 10k cycles against a scoreboard -> every accepted op is answered exactly once, in order, with the correct id/product; no requester is starved longer than NUM_REQ-1 grants.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one pipelined multiplier among NUM_REQ requesters
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/ready : per-requester handshake (at most one ready high)
//   req_a, req_b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready: tagged result handshake with backpressure
//   resp_id, resp_p : owner of the result and low WIDTH bits of a*b
//   inflight        : ops currently held in the pipeline
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int MUL_LATENCY = 3,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_p,
    output logic [2:0]               inflight
);
    logic [MUL_LATENCY-1:0] sv;
    logic [ID_W-1:0]        sid [MUL_LATENCY];
    logic [WIDTH-1:0]       sp  [MUL_LATENCY];
    logic [ID_W-1:0]        ptr, gid;
    logic [WIDTH-1:0]       ga, gb, prod;
    logic                   adv, hs, found, out_hs;
    int                     gi, best, d;

    assign resp_valid = sv[MUL_LATENCY-1];
    assign resp_id    = sid[MUL_LATENCY-1];
    assign resp_p     = sp[MUL_LATENCY-1];
    assign adv        = !(resp_valid && !resp_ready);
    assign out_hs     = resp_valid && resp_ready;

    // Priority distance d counts positions after ptr; smallest distance among valid requesters wins.
    always_comb begin
        gi    = 0;
        best  = NUM_REQ;
        found = 1'b0;
        d     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
            if (req_valid[i] && d < best) begin
                best  = d;
                gi    = i;
                found = 1'b1;
            end
        end
        hs  = found && adv;
        gid = ID_W'(gi);
        ga  = '0;
        gb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = hs && (i == gi);
            if (i == gi) begin
                ga = req_a[i*WIDTH +: WIDTH];
                gb = req_b[i*WIDTH +: WIDTH];
            end
        end
        prod = ga * gb;
    end

    // Stage payloads only move with a valid op so resp_id/resp_p keep the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv       <= '0;
            ptr      <= ID_W'(NUM_REQ - 1);
            inflight <= 3'd0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                sid[s] <= '0;
                sp[s]  <= '0;
            end
        end else begin
            if (hs)
                ptr <= gid;
            if (hs != out_hs)
                inflight <= hs ? inflight + 3'd1 : inflight - 3'd1;
            if (adv) begin
                sv[0] <= hs;
                if (hs) begin
                    sid[0] <= gid;
                    sp[0]  <= prod;
                end
                for (int s = 1; s < MUL_LATENCY; s++) begin
                    sv[s] <= sv[s-1];
                    if (sv[s-1]) begin
                        sid[s] <= sid[s-1];
                        sp[s]  <= sp[s-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and randomized checks of the shared multiplier arbiter
module tb_mult_share_arbiter;
    logic        clk, rst;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_p;
    logic [2:0]  inflight;
    int checks = 0;
    int errors = 0;

    mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .MUL_LATENCY(3), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_p(resp_p), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || inflight !== 3'd0 || resp_id !== 2'd0 || resp_p !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: got v=%b inf=%0d id=%0d p=%h exp v=0 inf=0 id=0 p=0", resp_valid, inflight, resp_id, resp_p);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 0000", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = (k == 0) ? 4'b0001 : 4'b0000;
            req_a = 64'd3;
            req_b = 64'd5;
            resp_ready = 1'b1;
            #1;
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_ready: got %b exp 0001", req_ready);
                end
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd1) begin
                    errors++;
                    $display("FAIL single_wait k=%0d: got v=%b inf=%0d exp v=0 inf=1", k, resp_valid, inflight);
                end
            end
            if (k == 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 16'd15 || inflight !== 3'd1) begin
                    errors++;
                    $display("FAIL single_resp: got v=%b id=%0d p=%0d inf=%0d exp v=1 id=0 p=15 inf=1", resp_valid, resp_id, resp_p, inflight);
                end
            end
            if (k == 4) begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd0) begin
                    errors++;
                    $display("FAIL single_done: got v=%b inf=%0d exp v=0 inf=0", resp_valid, inflight);
                end
            end
        end
    endtask

    task automatic test_rotate();
        int id;
        do_reset();
        req_a = {16'd4, 16'd3, 16'd2, 16'd1};
        req_b = {16'd2, 16'd2, 16'd2, 16'd2};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid = (k < 8) ? 4'hF : 4'h0;
            resp_ready = 1'b1;
            #1;
            if (k < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    errors++;
                    $display("FAIL rotate_grant k=%0d: got %b exp %b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 3 && k < 11) begin
                id = (k - 3) % 4;
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(id) || resp_p !== 16'(2 * (id + 1))) begin
                    errors++;
                    $display("FAIL rotate_resp k=%0d: got v=%b id=%0d p=%0d exp v=1 id=%0d p=%0d", k, resp_valid, resp_id, resp_p, id, 2 * (id + 1));
                end
            end
            if (k == 11) begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd0) begin
                    errors++;
                    $display("FAIL rotate_idle: got v=%b inf=%0d exp v=0 inf=0", resp_valid, inflight);
                end
            end
        end
    endtask

    task automatic test_stall();
        req_a = {16'd13, 16'd12, 16'd11, 16'd10};
        req_b = {16'd3, 16'd3, 16'd3, 16'd3};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid = (k < 8) ? 4'hF : 4'h0;
            resp_ready = (k < 3 || k >= 8);
            #1;
            if (k < 3) begin
                checks++;
                if (req_ready !== 4'(1 << k)) begin
                    errors++;
                    $display("FAIL stall_fill k=%0d: got %b exp %b", k, req_ready, 4'(1 << k));
                end
            end else if (k < 8) begin
                checks++;
                if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 16'd30 || inflight !== 3'd3) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d: got rdy=%b v=%b id=%0d p=%0d inf=%0d exp rdy=0000 v=1 id=0 p=30 inf=3", k, req_ready, resp_valid, resp_id, resp_p, inflight);
                end
            end else if (k < 11) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(k - 8) || resp_p !== 16'((k - 8 + 10) * 3) || inflight !== 3'(11 - k)) begin
                    errors++;
                    $display("FAIL stall_drain k=%0d: got v=%b id=%0d p=%0d inf=%0d exp v=1 id=%0d p=%0d inf=%0d", k, resp_valid, resp_id, resp_p, inflight, k - 8, (k - 8 + 10) * 3, 11 - k);
                end
            end else begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd0) begin
                    errors++;
                    $display("FAIL stall_idle: got v=%b inf=%0d exp v=0 inf=0", resp_valid, inflight);
                end
            end
        end
    endtask

    task automatic test_arith();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = (k < 2) ? 4'b0100 : 4'b0000;
            req_a = (k == 0) ? {16'd0, 16'hFFFF, 32'd0} : {16'd0, 16'h0100, 32'd0};
            req_b = req_a;
            resp_ready = 1'b1;
            #1;
            if (k < 2) begin
                checks++;
                if (req_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL arith_grant k=%0d: got %b exp 0100", k, req_ready);
                end
            end
            if (k == 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_p !== 16'h0001) begin
                    errors++;
                    $display("FAIL arith_ffff: got v=%b id=%0d p=%h exp v=1 id=2 p=0001", resp_valid, resp_id, resp_p);
                end
            end
            if (k == 4) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_p !== 16'h0000) begin
                    errors++;
                    $display("FAIL arith_0100: got v=%b id=%0d p=%h exp v=1 id=2 p=0000", resp_valid, resp_id, resp_p);
                end
            end
        end
    endtask

    task automatic test_wrap();
        req_a = {16'd7, 32'd0, 16'd2};
        req_b = {16'd9, 32'd0, 16'd11};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = (k < 2) ? 4'b1001 : 4'b0000;
            resp_ready = 1'b1;
            #1;
            if (k < 2) begin
                checks++;
                if (req_ready !== ((k == 0) ? 4'b1000 : 4'b0001)) begin
                    errors++;
                    $display("FAIL wrap_grant k=%0d: got %b exp %b", k, req_ready, (k == 0) ? 4'b1000 : 4'b0001);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== ((k == 3) ? 2'd3 : 2'd0) || resp_p !== ((k == 3) ? 16'd63 : 16'd22)) begin
                    errors++;
                    $display("FAIL wrap_resp k=%0d: got v=%b id=%0d p=%0d exp v=1 id=%0d p=%0d", k, resp_valid, resp_id, resp_p, (k == 3) ? 3 : 0, (k == 3) ? 63 : 22);
                end
            end
            if (k == 5) begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd0) begin
                    errors++;
                    $display("FAIL wrap_idle: got v=%b inf=%0d exp v=0 inf=0", resp_valid, inflight);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        req_a = {32'd0, 16'd5, 16'd6};
        req_b = {32'd0, 16'd5, 16'd7};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000;
            resp_ready = (k < 2);
            #1;
            if (k == 2) begin
                checks++;
                if (inflight !== 3'd2) begin
                    errors++;
                    $display("FAIL rstmid_inflight: got %0d exp 2", inflight);
                end
            end
            if (k == 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 16'd42) begin
                    errors++;
                    $display("FAIL rstmid_pre: got v=%b id=%0d p=%0d exp v=1 id=0 p=42", resp_valid, resp_id, resp_p);
                end
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || inflight !== 3'd0 || resp_id !== 2'd0 || resp_p !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b inf=%0d id=%0d p=%0d exp v=0 inf=0 id=0 p=0", resp_valid, inflight, resp_id, resp_p);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = (k == 0) ? 4'b1001 : 4'b0000;
            resp_ready = 1'b1;
            #1;
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL rstmid_prio: got %b exp 0001", req_ready);
                end
            end else if (k < 3) begin
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_ghost k=%0d: got v=%b exp v=0", k, resp_valid);
                end
            end else if (k == 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 16'd42) begin
                    errors++;
                    $display("FAIL rstmid_after: got v=%b id=%0d p=%0d exp v=1 id=0 p=42", resp_valid, resp_id, resp_p);
                end
            end else begin
                checks++;
                if (resp_valid !== 1'b0 || inflight !== 3'd0) begin
                    errors++;
                    $display("FAIL rstmid_idle: got v=%b inf=%0d exp v=0 inf=0", resp_valid, inflight);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        mv [3];
        logic [1:0]  mid [3];
        logic [15:0] mp [3];
        logic [31:0] full;
        int mptr, mcnt, g, idx, worst;
        int wt [4];
        logic madv;
        logic [3:0] exp_rdy;
        do_reset();
        mptr = 3;
        mcnt = 0;
        for (int s = 0; s < 3; s++) begin
            mv[s] = 1'b0;
            mid[s] = '0;
            mp[s] = '0;
        end
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            madv = !(mv[2] && !resp_ready);
            g = -1;
            if (madv)
                for (int k = 1; k <= 4; k++) begin
                    idx = (mptr + k) % 4;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_grant c=%0d: got %b exp %b", c, req_ready, exp_rdy);
            end
            checks++;
            if (resp_valid !== mv[2] || (mv[2] && (resp_id !== mid[2] || resp_p !== mp[2]))) begin
                errors++;
                $display("FAIL rand_resp c=%0d: got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", c, resp_valid, resp_id, resp_p, mv[2], mid[2], mp[2]);
            end
            checks++;
            if (inflight !== 3'(mcnt)) begin
                errors++;
                $display("FAIL rand_inflight c=%0d: got %0d exp %0d", c, inflight, mcnt);
            end
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || i == g) wt[i] = 0;
                else if (g >= 0) wt[i]++;
                if (wt[i] > worst) worst = wt[i];
            end
            if (g >= 0) begin
                checks++;
                if (worst > 3) begin
                    errors++;
                    $display("FAIL rand_starve c=%0d: got wait %0d exp <= 3", c, worst);
                end
            end
            mcnt = mcnt + ((g >= 0) ? 1 : 0) - ((mv[2] && resp_ready) ? 1 : 0);
            if (madv) begin
                for (int s = 2; s > 0; s--) begin
                    mv[s] = mv[s-1];
                    mid[s] = mid[s-1];
                    mp[s] = mp[s-1];
                end
                mv[0] = (g >= 0);
                if (g >= 0) begin
                    full = {16'd0, req_a[g*16 +: 16]} * {16'd0, req_b[g*16 +: 16]};
                    mid[0] = 2'(g);
                    mp[0] = full[15:0];
                    mptr = g;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        test_reset();
        test_single();
        test_rotate();
        test_stall();
        test_arith();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
